keypad_entry: RTL and testbench

//   Scans a 4x4 matrix keypad: drives columns, reads rows, debounces, decodes keys.

---
 rtl/keypad_entry.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry
//   Scans a 4x4 active-low matrix keypad, debounces the scan snapshots,
//   decodes the confirmed key and runs a decimal entry accumulator whose
//   value is committed downstream on the ENTER key.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   key_row[3:0]  keypad rows, active-low, asynchronous to clk
//   key_col[3:0]  keypad columns, active-low, exactly one low at a time
//   key_valid     1-cycle pulse on a confirmed key press
//   key_code[3:0] code of the last confirmed key
//   entry_value   live entered value (binary)
//   entry_digits  digits entered so far (0..5)
//   entry_err     1-cycle pulse when a digit is rejected
//   commit_value  value latched by ENTER
//   commit_valid  1-cycle pulse when commit_value is updated
module keypad_entry #(
  parameter logic [15:0] SCAN_DIV = 16'd5000,
  parameter logic [3:0]  DEBOUNCE = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_digits,
  output logic        entry_err,
  output logic [15:0] commit_value,
  output logic        commit_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Row synchronizer
  logic [3:0]  row_meta_q;
  logic [3:0]  row_sync_q;

  // Column scanner
  logic [15:0] div_q;
  logic [1:0]  col_q;
  logic [3:0]  key_col_q;
  logic [15:0] snap_q;
  logic        scan_done_q;

  // Debounce FSM
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cand_q;
  logic        key_valid_q;
  logic [3:0]  key_code_q;

  // Entry accumulator
  logic [15:0] entry_value_q;
  logic [2:0]  entry_digits_q;
  logic        entry_err_q;
  logic [15:0] commit_value_q;
  logic        commit_valid_q;

  // Snapshot classification and entry arithmetic
  logic [4:0]  snap_pop_s;
  logic [3:0]  snap_idx_s;
  logic        snap_none_s;
  logic        snap_single_s;
  logic [19:0] appended_s;
  logic        digit_ok_s;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] low_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Snapshot index is {column, row}; maps to the printed key legend.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'hE;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'h0;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hF;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= key_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Column scanner: each column is driven for SCAN_DIV clocks and its rows are
  // captured on the last clock; scan_done_q flags a complete 16-bit snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= 16'd0;
      col_q       <= 2'd0;
      key_col_q   <= 4'b1110;
      snap_q      <= 16'd0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (div_q == SCAN_DIV - 16'd1) begin
        div_q                        <= 16'd0;
        snap_q[{col_q, 2'b00} +: 4]  <= ~row_sync_q;
        col_q                        <= col_q + 2'd1;
        key_col_q                    <= {key_col_q[2:0], key_col_q[3]};
        if (col_q == 2'd3) begin
          scan_done_q <= 1'b1;
        end else begin
          scan_done_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + 16'd1;
      end
    end
  end

  // Snapshot classification and digit-append arithmetic (20-bit to hold value*10+9).
  always_comb begin
    snap_pop_s    = popcount16(snap_q);
    snap_idx_s    = low_index(snap_q);
    snap_none_s   = (snap_pop_s == 5'd0);
    snap_single_s = (snap_pop_s == 5'd1);
    appended_s    = ({4'd0, entry_value_q} * 20'd10) + {16'd0, key_code_q};
    digit_ok_s    = (entry_digits_q < 3'd5) && (appended_s <= 20'd65535);
  end

  // Debounce FSM, advanced once per completed scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done_q) begin
        case (state_q)
          ST_IDLE: begin
            if (snap_single_s) begin
              cand_q <= snap_idx_s;
              cnt_q  <= 4'd1;
              // A debounce depth of one confirms on the very first scan.
              if (DEBOUNCE <= 4'd1) begin
                state_q     <= ST_HELD;
                key_valid_q <= 1'b1;
                key_code_q  <= key_map(snap_idx_s);
              end else begin
                state_q <= ST_PRESS;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_PRESS: begin
            if (snap_single_s && (snap_idx_s == cand_q)) begin
              cnt_q <= cnt_q + 4'd1;
              if ((cnt_q + 4'd1) >= DEBOUNCE) begin
                state_q     <= ST_HELD;
                key_valid_q <= 1'b1;
                key_code_q  <= key_map(cand_q);
              end else begin
                state_q <= ST_PRESS;
              end
            end else if (snap_single_s) begin
              cand_q <= snap_idx_s;
              cnt_q  <= 4'd1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (snap_none_s) begin
              cnt_q <= 4'd1;
              if (DEBOUNCE <= 4'd1) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          ST_RELEASE: begin
            if (snap_none_s) begin
              cnt_q <= cnt_q + 4'd1;
              if ((cnt_q + 4'd1) >= DEBOUNCE) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Entry accumulator, acting on the cycle after each confirmed key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_value_q  <= 16'd0;
      entry_digits_q <= 3'd0;
      entry_err_q    <= 1'b0;
      commit_value_q <= 16'd0;
      commit_valid_q <= 1'b0;
    end else begin
      entry_err_q    <= 1'b0;
      commit_valid_q <= 1'b0;
      if (key_valid_q) begin
        case (key_code_q)
          4'hA: begin
            entry_value_q  <= 16'd0;
            entry_digits_q <= 3'd0;
          end
          4'hB: begin
            if (entry_digits_q != 3'd0) begin
              entry_value_q  <= entry_value_q / 16'd10;
              entry_digits_q <= entry_digits_q - 3'd1;
            end else begin
              entry_value_q  <= entry_value_q;
            end
          end
          4'hC: begin
            commit_value_q <= entry_value_q;
            commit_valid_q <= 1'b1;
            entry_value_q  <= 16'd0;
            entry_digits_q <= 3'd0;
          end
          4'hD, 4'hE, 4'hF: begin
            entry_value_q <= entry_value_q;
          end
          default: begin
            // Codes 0..9 are decimal digits.
            if (digit_ok_s) begin
              entry_value_q  <= appended_s[15:0];
              entry_digits_q <= entry_digits_q + 3'd1;
            end else begin
              entry_err_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign key_col      = key_col_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign entry_value  = entry_value_q;
  assign entry_digits = entry_digits_q;
  assign entry_err    = entry_err_q;
  assign commit_value = commit_value_q;
  assign commit_valid = commit_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry (SCAN_DIV=4, DEBOUNCE=2). A keypad model turns
// the set of pressed keys into row levels; stimulus is applied one full scan
// at a time and a key-level reference model predicts presses and entry state.
module tb_keypad_entry;

  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_value;
  logic [2:0]  entry_digits;
  logic        entry_err;
  logic [15:0] commit_value;
  logic        commit_valid;

  logic [15:0] pressed;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(16'd4), .DEBOUNCE(4'd2)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_row      (key_row),
    .key_col      (key_col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .entry_value  (entry_value),
    .entry_digits (entry_digits),
    .entry_err    (entry_err),
    .commit_value (commit_value),
    .commit_valid (commit_valid)
  );

  // Physical keypad: a pressed key shorts its row to the driven (low) column.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (key_col[c] == 1'b0) key_row = key_row & ~pressed[4*c +: 4];
    end
  end

  // Pulse counters observed from the DUT.
  int mon_kv = 0;
  int mon_err = 0;
  int mon_commit = 0;
  always @(posedge clk) begin
    if (key_valid === 1'b1) mon_kv <= mon_kv + 1;
    if (entry_err === 1'b1) mon_err <= mon_err + 1;
    if (commit_valid === 1'b1) mon_commit <= mon_commit + 1;
  end

  // Reference model state.
  logic [3:0]  km [4][4];
  logic [15:0] hist [$];
  bit          armed;
  int          m_value, m_digits, exp_kv, exp_err, exp_commit;
  logic [3:0]  exp_code;
  logic [15:0] exp_commit_val;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  int          kv_before, sel, hold, gap;
  logic [15:0] rk;
  logic [3:0]  exp_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] b;
    b = 16'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (km[r][c] == code) b = 16'd1 << (4*c + r);
    return b;
  endfunction

  function automatic bit window_all(input logic [15:0] v);
    if (hist.size() < DEB) return 1'b0;
    foreach (hist[i]) if (hist[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    armed          = 1'b1;
    m_value        = 0;
    m_digits       = 0;
    exp_code       = 4'h0;
    exp_commit_val = 16'd0;
  endtask

  task automatic model_press(input logic [15:0] keys);
    int idx;
    int d;
    idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    exp_code = km[idx % 4][idx / 4];
    exp_kv++;
    d = int'(exp_code);
    if (d <= 9) begin
      if (m_digits < 5 && m_value * 10 + d <= 65535) begin
        m_value  = m_value * 10 + d;
        m_digits = m_digits + 1;
      end else begin
        exp_err++;
      end
    end else if (exp_code == 4'hA) begin
      m_value = 0; m_digits = 0;
    end else if (exp_code == 4'hB) begin
      if (m_digits > 0) begin
        m_value = m_value / 10; m_digits = m_digits - 1;
      end
    end else if (exp_code == 4'hC) begin
      exp_commit_val = 16'(m_value);
      exp_commit++;
      m_value = 0; m_digits = 0;
    end
  endtask

  // A key press is confirmed when DEB consecutive scans show the same single
  // key after the keypad was released; release needs DEB empty scans.
  task automatic model_scan(input logic [15:0] keys);
    hist.push_back(keys);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (armed) begin
      if ($countones(keys) == 1 && window_all(keys)) begin
        armed = 1'b0;
        model_press(keys);
      end
    end else if (window_all(16'd0)) begin
      armed = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("kv_count", mon_kv, exp_kv);
    chk("key_code", key_code, exp_code);
    chk("entry_value", entry_value, m_value);
    chk("entry_digits", entry_digits, m_digits);
    chk("err_count", mon_err, exp_err);
    chk("commit_count", mon_commit, exp_commit);
    chk("commit_value", commit_value, exp_commit_val);
  endtask

  task automatic check_reset_outputs();
    chk("rst_key_col", key_col, 4'b1110);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_code", key_code, 4'h0);
    chk("rst_entry_value", entry_value, 16'd0);
    chk("rst_entry_digits", entry_digits, 3'd0);
    chk("rst_entry_err", entry_err, 1'b0);
    chk("rst_commit_value", commit_value, 16'd0);
    chk("rst_commit_valid", commit_valid, 1'b0);
  endtask

  // One full scan (16 clocks) with a fixed key set; outputs from the previous
  // scan are checked a few clocks in, once they have settled.
  task automatic do_scan(input logic [15:0] keys);
    pressed = keys;
    repeat (4) @(negedge clk);
    check_all();
    repeat (12) @(negedge clk);
    model_scan(keys);
  endtask

  task automatic press_key(input logic [3:0] code);
    repeat (3) do_scan(key_bit(code));
    repeat (2) do_scan(16'd0);
  endtask

  // Part of a scan with keys held, then an asynchronous reset.
  task automatic reset_mid(input logic [15:0] keys);
    pressed = keys;
    repeat (4) @(negedge clk);
    check_all();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    km = '{'{4'h1, 4'h2, 4'h3, 4'hA},
           '{4'h4, 4'h5, 4'h6, 4'hB},
           '{4'h7, 4'h8, 4'h9, 4'hC},
           '{4'hE, 4'h0, 4'hF, 4'hD}};
    exp_kv = 0; exp_err = 0; exp_commit = 0;
    model_reset();
    pressed = 16'd0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Column rotation over two idle scans.
    for (int n = 0; n < 32; n++) begin
      exp_col = 4'hF & ~(4'b0001 << ((n / 4) % 4));
      chk("col_rotate", key_col, exp_col);
      @(negedge clk);
    end
    model_scan(16'd0);
    model_scan(16'd0);

    // Hold '7' for three scans: one press, no repeat.
    kv_before = mon_kv;
    press_key(4'h7);
    chk("seven_once", mon_kv - kv_before, 1);
    chk("seven_code", key_code, 4'h7);
    chk("seven_value", entry_value, 16'd7);
    chk("seven_digits", entry_digits, 3'd1);

    // Bounce: one scan of '5' is not a press.
    kv_before = mon_kv;
    do_scan(key_bit(4'h5));
    repeat (2) do_scan(16'd0);
    chk("bounce_none", mon_kv - kv_before, 0);

    // One-scan release glitch while '8' is held: single press.
    kv_before = mon_kv;
    repeat (3) do_scan(key_bit(4'h8));
    do_scan(16'd0);
    repeat (2) do_scan(key_bit(4'h8));
    repeat (2) do_scan(16'd0);
    chk("glitch_once", mon_kv - kv_before, 1);

    // Clear, then fill to the maximum value and overflow.
    press_key(4'hA);
    press_key(4'h6); press_key(4'h5); press_key(4'h5); press_key(4'h3); press_key(4'h5);
    chk("max_value", entry_value, 16'd65535);
    kv_before = mon_err;
    press_key(4'h1);
    chk("overflow_err", mon_err - kv_before, 1);
    chk("overflow_hold", entry_value, 16'd65535);
    press_key(4'hC);
    chk("commit_max", commit_value, 16'd65535);
    chk("commit_clears", entry_value, 16'd0);

    // Backspace, clear, backspace on empty.
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'hB);
    chk("bksp_value", entry_value, 16'd12);
    chk("bksp_digits", entry_digits, 3'd2);
    press_key(4'hA);
    press_key(4'hB);
    chk("empty_bksp", entry_digits, 3'd0);

    // Two keys at once are never a press.
    kv_before = mon_kv;
    repeat (3) do_scan(key_bit(4'h1) | key_bit(4'h2));
    repeat (2) do_scan(16'd0);
    chk("multi_none", mon_kv - kv_before, 0);

    // Reset while in PRESS; the next press needs a full debounce again.
    press_key(4'h4);
    do_scan(key_bit(4'h1));
    reset_mid(key_bit(4'h1));
    kv_before = mon_kv;
    do_scan(key_bit(4'h1));
    repeat (2) do_scan(16'd0);
    chk("post_reset_debounce", mon_kv - kv_before, 0);
    press_key(4'h9);
    chk("post_reset_press", entry_value, 16'd9);

    // Randomized key activity against the model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) rk = 16'd1 << $urandom_range(0, 15);
      else if (sel < 9) rk = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
      else rk = 16'd0;
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(1, 3);
      repeat (hold) do_scan(rk);
      repeat (gap) do_scan(16'd0);
    end
    do_scan(16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
